// File: rtl/mem_resp_tracker_if.sv
// Per-lane data-bus response signals between the memory stage and the response tracker.
// Lane NLANE-1 carries the older instruction.
interface mem_resp_tracker_if #(
   parameter int unsigned NLANE = 2
);
   logic [NLANE-1:0]       reqValid;
   logic [NLANE-1:0]       addrOk;
   logic [NLANE-1:0]       dataOk;
   logic [NLANE-1:0][31:0] respData;
   logic [NLANE-1:0][1:0]  addrLo;
   logic [NLANE-1:0][1:0]  msize;
   logic [NLANE-1:0]       ldUnsigned;
   logic [NLANE-1:0]       isLoad;
   logic                   advance;
   logic                   flush;
   logic [NLANE-1:0]       reqFinish;
   logic                   stallM;
   logic [NLANE-1:0][31:0] rdata;
   logic [NLANE-1:0]       rdataValid;

   modport master (
      output reqValid, addrOk, dataOk, respData, addrLo, msize, ldUnsigned, isLoad,
             advance, flush,
      input  reqFinish, stallM, rdata, rdataValid
   );

   modport slave (
      input  reqValid, addrOk, dataOk, respData, addrLo, msize, ldUnsigned, isLoad,
             advance, flush,
      output reqFinish, stallM, rdata, rdataValid
   );
endinterface

// File: rtl/mem_resp_tracker.sv
// Memory-stage response tracker: per-lane outstanding-transaction FSM, stall generation and
// aligned, sign/zero-extended load data for writeback.
module mem_resp_tracker #(
   parameter int unsigned NLANE = 2
) (
   input logic               clk,
   input logic               reset,
   mem_resp_tracker_if.slave bus
);
   localparam logic [1:0] MSIZE1 = 2'd0;
   localparam logic [1:0] MSIZE2 = 2'd1;

   typedef enum logic [1:0] {StIdle, StWaitData, StDone, StDrain} laneStateT;

   laneStateT        stateQ [NLANE];
   laneStateT        stateD [NLANE];
   logic [31:0]      dataQ  [NLANE];
   logic [31:0]      dataD  [NLANE];
   logic [NLANE-1:0] accept;
   logic [NLANE-1:0] completing;
   logic [NLANE-1:0] laneStall;
   logic [NLANE-1:0] loadValid;

   function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] lo,
                                          input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = word[{lo[1], 4'b0000} +: 16];
      case (size)
         MSIZE1:  extend = {{24{b[7] & ~uns}}, b};
         MSIZE2:  extend = {{16{h[15] & ~uns}}, h};
         default: extend = word;
      endcase
   endfunction

   assign accept = bus.reqValid & bus.addrOk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NLANE; i++) begin
            stateQ[i] <= StIdle;
            dataQ[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NLANE; i++) begin
            stateQ[i] <= stateD[i];
            dataQ[i]  <= dataD[i];
         end
      end
   end

   // Completion and stall decode; both are combinational from the bus response.
   always_comb begin
      for (int i = 0; i < NLANE; i++) begin
         completing[i] = 1'b0;
         laneStall[i]  = 1'b0;
         case (stateQ[i])
            StIdle: begin
               completing[i] = accept[i] & bus.dataOk[i];
               laneStall[i]  = bus.reqValid[i] & ~(bus.addrOk[i] & bus.dataOk[i]);
            end
            StWaitData: begin
               completing[i] = bus.dataOk[i];
               laneStall[i]  = ~bus.dataOk[i];
            end
            StDrain: laneStall[i] = ~bus.dataOk[i];
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NLANE; i++) begin
         stateD[i] = stateQ[i];
         dataD[i]  = dataQ[i];
         unique case (stateQ[i])
            StIdle: begin
               if (!bus.flush) begin
                  if (completing[i] && !bus.advance) begin
                     stateD[i] = StDone;
                     dataD[i]  = bus.respData[i];
                  end else if (accept[i] && !bus.dataOk[i]) begin
                     stateD[i] = StWaitData;
                  end
               end
            end
            StWaitData: begin
               // The bus cannot cancel an accepted request, so a flush must drain it.
               if (bus.flush) begin
                  stateD[i] = bus.dataOk[i] ? StIdle : StDrain;
               end else if (bus.dataOk[i]) begin
                  if (bus.advance) begin
                     stateD[i] = StIdle;
                  end else begin
                     stateD[i] = StDone;
                     dataD[i]  = bus.respData[i];
                  end
               end
            end
            StDone: begin
               if (bus.advance || bus.flush) stateD[i] = StIdle;
            end
            StDrain: begin
               if (bus.dataOk[i]) stateD[i] = StIdle;
            end
            default: stateD[i] = StIdle;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NLANE; i++) begin
         loadValid[i] = bus.isLoad[i] & (completing[i] | (stateQ[i] == StDone)) & ~bus.flush;
         bus.reqFinish[i]  = (stateQ[i] == StDone);
         bus.rdataValid[i] = loadValid[i];
         bus.rdata[i]      = '0;
         if (loadValid[i]) begin
            bus.rdata[i] = extend(completing[i] ? bus.respData[i] : dataQ[i], bus.addrLo[i],
                                  bus.msize[i], bus.ldUnsigned[i]);
         end
      end
   end

   assign bus.stallM = |laneStall;

endmodule

// File: tb/tb_mem_resp_tracker.sv
// Self-checking bench for mem_resp_tracker: directed scenarios plus randomized two-lane
// transactions checked against a transaction-level reference model.
module tb_mem_resp_tracker;
   localparam int unsigned NLANE = 2;
   localparam logic [1:0] MSIZE1 = 2'd0;
   localparam logic [1:0] MSIZE2 = 2'd1;
   localparam logic [1:0] MSIZE4 = 2'd2;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   mem_resp_tracker_if #(.NLANE(NLANE)) bus ();

   mem_resp_tracker #(.NLANE(NLANE)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Load extraction from the architectural rules, using plain arithmetic.
   function automatic logic [31:0] refExt(input logic [31:0] w, input logic [1:0] lo,
                                          input logic [1:0] size, input logic uns);
      longint v;
      if (size == MSIZE1) begin
         v = longint'((w >> (8 * lo)) & 32'hFF);
         if (!uns && v >= 128) v = v - 256;
      end else if (size == MSIZE2) begin
         v = longint'((w >> (16 * (lo / 2))) & 32'hFFFF);
         if (!uns && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(w);
      end
      return v[31:0];
   endfunction

   task automatic idleInputs();
      bus.reqValid   = '0;
      bus.addrOk     = '0;
      bus.dataOk     = '0;
      bus.respData   = '0;
      bus.addrLo     = '0;
      bus.msize      = '0;
      bus.ldUnsigned = '0;
      bus.isLoad     = '0;
      bus.advance    = 1'b1;
      bus.flush      = 1'b0;
   endtask

   task automatic setLane(input int i, input logic v, input logic ao, input logic dok,
                          input logic [31:0] d, input logic [1:0] lo, input logic [1:0] sz,
                          input logic uns, input logic ld);
      bus.reqValid[i]   = v;
      bus.addrOk[i]     = ao;
      bus.dataOk[i]     = dok;
      bus.respData[i]   = d;
      bus.addrLo[i]     = lo;
      bus.msize[i]      = sz;
      bus.ldUnsigned[i] = uns;
      bus.isLoad[i]     = ld;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idleInputs();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.stallM !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", bus.stallM); end
      checks++; if (bus.reqFinish !== 2'b00) begin failures++; $display("FAIL reset_finish: got %b want 00", bus.reqFinish); end
      checks++; if (bus.rdataValid !== 2'b00) begin failures++; $display("FAIL reset_valid: got %b want 00", bus.rdataValid); end
      checks++; if (bus.rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
      bus.reqValid = 2'b01;
      #1;
      checks++; if (bus.stallM !== 1'b1) begin failures++; $display("FAIL reset_valid_stall: got %b want 1", bus.stallM); end
      bus.reqValid = 2'b00;
      nextCycle();
      reset = 1'b0;
   endtask

   task automatic test_load_same_cycle();
      idleInputs();
      setLane(1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 2'd0, MSIZE4, 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (bus.rdata[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata: got %h want deadbeef", bus.rdata[1]); end
      checks++; if (bus.rdataValid !== 2'b10) begin failures++; $display("FAIL lw_valid: got %b want 10", bus.rdataValid); end
      checks++; if (bus.stallM !== 1'b0) begin failures++; $display("FAIL lw_stall: got %b want 0", bus.stallM); end
      nextCycle();
      idleInputs();
      @(negedge clk);
      checks++; if (bus.reqFinish !== 2'b00) begin failures++; $display("FAIL lw_finish: got %b want 00", bus.reqFinish); end
      nextCycle();
   endtask

   task automatic test_byte_wait(input logic uns);
      logic [31:0] want;
      want = uns ? 32'h00000080 : 32'hFFFFFF80;
      idleInputs();
      bus.advance = 1'b0;
      for (int c = 0; c < 3; c++) begin
         setLane(0, c == 0, c == 0, 1'b0, $urandom, 2'd3, MSIZE1, uns, 1'b1);
         @(negedge clk);
         checks++; if (bus.stallM !== 1'b1) begin failures++; $display("FAIL lb_stall c%0d: got %b want 1", c, bus.stallM); end
         checks++; if (bus.rdataValid[0] !== 1'b0) begin failures++; $display("FAIL lb_early_valid c%0d: got %b want 0", c, bus.rdataValid[0]); end
         nextCycle();
      end
      setLane(0, 1'b0, 1'b0, 1'b1, 32'h80112233, 2'd3, MSIZE1, uns, 1'b1);
      bus.advance = 1'b1;
      @(negedge clk);
      checks++; if (bus.stallM !== 1'b0) begin failures++; $display("FAIL lb_done_stall: got %b want 0", bus.stallM); end
      checks++; if (bus.rdata[0] !== want) begin failures++; $display("FAIL lb_rdata uns=%b: got %h want %h", uns, bus.rdata[0], want); end
      checks++; if (bus.rdataValid[0] !== 1'b1) begin failures++; $display("FAIL lb_valid: got %b want 1", bus.rdataValid[0]); end
      nextCycle();
      idleInputs();
      @(negedge clk);
      checks++; if (bus.reqFinish !== 2'b00) begin failures++; $display("FAIL lb_finish: got %b want 00", bus.reqFinish); end
      nextCycle();
   endtask

   task automatic test_joint_stall();
      idleInputs();
      bus.advance = 1'b0;
      setLane(1, 1'b1, 1'b1, 1'b0, $urandom, 2'd2, MSIZE2, 1'b0, 1'b1);
      setLane(0, 1'b1, 1'b1, 1'b0, $urandom, 2'd0, MSIZE4, 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (bus.stallM !== 1'b1) begin failures++; $display("FAIL joint_c0_stall: got %b want 1", bus.stallM); end
      for (int c = 1; c <= 4; c++) begin
         nextCycle();
         bus.reqValid = 2'b00;
         bus.addrOk   = 2'b00;
         bus.dataOk   = {c == 1, c == 4};
         bus.respData[1] = (c == 1) ? 32'h80015A5A : $urandom;
         bus.respData[0] = $urandom;
         bus.advance  = (c == 4);
         @(negedge clk);
         checks++; if (bus.stallM !== (c < 4)) begin failures++; $display("FAIL joint_stall c%0d: got %b want %b", c, bus.stallM, c < 4); end
         checks++; if (bus.reqFinish !== {c >= 2, 1'b0}) begin failures++; $display("FAIL joint_finish c%0d: got %b want %b", c, bus.reqFinish, {c >= 2, 1'b0}); end
         checks++; if (bus.rdataValid !== 2'b10) begin failures++; $display("FAIL joint_valid c%0d: got %b want 10", c, bus.rdataValid); end
         checks++; if (bus.rdata[1] !== 32'hFFFF8001) begin failures++; $display("FAIL joint_rdata c%0d: got %h want ffff8001", c, bus.rdata[1]); end
      end
      nextCycle();
      idleInputs();
      @(negedge clk);
      checks++; if (bus.reqFinish !== 2'b00) begin failures++; $display("FAIL joint_after_finish: got %b want 00", bus.reqFinish); end
      nextCycle();
   endtask

   task automatic test_flush_drain();
      idleInputs();
      bus.advance = 1'b0;
      setLane(0, 1'b1, 1'b1, 1'b0, $urandom, 2'd0, MSIZE4, 1'b0, 1'b1);
      nextCycle();
      for (int c = 1; c <= 4; c++) begin
         setLane(0, 1'b0, 1'b0, c == 4, (c == 4) ? 32'h11111111 : $urandom, 2'd0, MSIZE4, 1'b0, 1'b1);
         bus.flush = (c == 1);
         @(negedge clk);
         checks++; if (bus.stallM !== (c < 4)) begin failures++; $display("FAIL drain_stall c%0d: got %b want %b", c, bus.stallM, c < 4); end
         checks++; if (bus.rdataValid !== 2'b00) begin failures++; $display("FAIL drain_valid c%0d: got %b want 00", c, bus.rdataValid); end
         checks++; if (bus.reqFinish !== 2'b00) begin failures++; $display("FAIL drain_finish c%0d: got %b want 00", c, bus.reqFinish); end
         nextCycle();
      end
      idleInputs();
      setLane(0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 2'd0, MSIZE4, 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (bus.rdata[0] !== 32'hCAFEF00D || bus.rdataValid !== 2'b01) begin failures++; $display("FAIL drain_next_load: got %h/%b want cafef00d/01", bus.rdata[0], bus.rdataValid); end
      checks++; if (bus.stallM !== 1'b0) begin failures++; $display("FAIL drain_next_stall: got %b want 0", bus.stallM); end
      nextCycle();
      idleInputs();
      @(negedge clk);
      checks++; if (bus.reqFinish !== 2'b00) begin failures++; $display("FAIL drain_next_finish: got %b want 00", bus.reqFinish); end
      nextCycle();
   endtask

   task automatic test_reset_mid();
      idleInputs();
      bus.advance = 1'b0;
      setLane(0, 1'b1, 1'b1, 1'b0, $urandom, 2'd0, MSIZE4, 1'b0, 1'b1);
      nextCycle();
      setLane(0, 1'b0, 1'b0, 1'b0, $urandom, 2'd0, MSIZE4, 1'b0, 1'b1);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.stallM !== 1'b0) begin failures++; $display("FAIL rstmid_stall: got %b want 0", bus.stallM); end
      checks++; if (bus.reqFinish !== 2'b00 || bus.rdataValid !== 2'b00) begin failures++; $display("FAIL rstmid_outputs: got %b/%b want 00/00", bus.reqFinish, bus.rdataValid); end
      checks++; if (bus.rdata !== 64'd0) begin failures++; $display("FAIL rstmid_rdata: got %h want 0", bus.rdata); end
      nextCycle();
      reset = 1'b0;
      // A stray data_ok must not complete anything after reset.
      setLane(0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA, 2'd0, MSIZE4, 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (bus.rdataValid !== 2'b00 || bus.stallM !== 1'b0) begin failures++; $display("FAIL rstmid_stray: got valid=%b stall=%b want 00/0", bus.rdataValid, bus.stallM); end
      nextCycle();
      idleInputs();
      @(negedge clk);
      checks++; if (bus.reqFinish !== 2'b00) begin failures++; $display("FAIL rstmid_finish: got %b want 00", bus.reqFinish); end
      nextCycle();
   endtask

   task automatic test_both_lhu();
      idleInputs();
      setLane(0, 1'b1, 1'b1, 1'b1, 32'h0000ABCD, 2'd0, MSIZE2, 1'b1, 1'b1);
      setLane(1, 1'b1, 1'b1, 1'b1, 32'h1234FFFF, 2'd0, MSIZE2, 1'b1, 1'b1);
      @(negedge clk);
      checks++; if (bus.rdata[0] !== 32'h0000ABCD) begin failures++; $display("FAIL lhu_lane0: got %h want 0000abcd", bus.rdata[0]); end
      checks++; if (bus.rdata[1] !== 32'h0000FFFF) begin failures++; $display("FAIL lhu_lane1: got %h want 0000ffff", bus.rdata[1]); end
      checks++; if (bus.rdataValid !== 2'b11 || bus.stallM !== 1'b0) begin failures++; $display("FAIL lhu_flags: got valid=%b stall=%b want 11/0", bus.rdataValid, bus.stallM); end
      nextCycle();
   endtask

   // Each group issues one transaction per active lane with random address/data latency;
   // the pipeline advances only once every lane has its data and an optional hold expires.
   task automatic test_random();
      for (int g = 0; g < 60; g++) begin
         bit          act [NLANE];
         bit          ld [NLANE];
         logic [1:0]  sz [NLANE];
         logic [1:0]  lo [NLANE];
         bit          uns [NLANE];
         logic [31:0] word [NLANE];
         int          aD [NLANE];
         int          doneAt [NLANE];
         int          last;
         int          hold;
         bit          expStall;
         bit          adv;
         logic [31:0] want;
         idleInputs();
         last = 0;
         for (int i = 0; i < NLANE; i++) begin
            act[i]  = ($urandom % 2) == 1;
            ld[i]   = ($urandom % 2) == 1;
            sz[i]   = 2'($urandom % 3);
            lo[i]   = (sz[i] == MSIZE1) ? 2'($urandom % 4) : (sz[i] == MSIZE2) ? 2'(2 * ($urandom % 2)) : 2'd0;
            uns[i]  = ($urandom % 2) == 1;
            word[i] = $urandom;
            aD[i]   = $urandom_range(0, 2);
            doneAt[i] = aD[i] + $urandom_range(0, 2);
         end
         if (!act[0] && !act[1]) act[0] = 1'b1;
         for (int i = 0; i < NLANE; i++) if (act[i] && doneAt[i] > last) last = doneAt[i];
         hold = $urandom_range(0, 2);
         for (int c = 0; c <= 8; c++) begin
            expStall = 1'b0;
            for (int i = 0; i < NLANE; i++) begin
               setLane(i, act[i] && c <= aD[i], act[i] && c == aD[i], act[i] && c == doneAt[i],
                       (c == doneAt[i]) ? word[i] : $urandom, lo[i], sz[i], uns[i], ld[i]);
               if (act[i] && c < doneAt[i]) expStall = 1'b1;
            end
            adv = !expStall && c >= last + hold;
            bus.advance = adv;
            @(negedge clk);
            checks++; if (bus.stallM !== expStall) begin failures++; $display("FAIL rnd_stall g%0d c%0d: got %b want %b", g, c, bus.stallM, expStall); end
            for (int i = 0; i < NLANE; i++) begin
               checks++; if (bus.reqFinish[i] !== (act[i] && c > doneAt[i])) begin failures++; $display("FAIL rnd_finish g%0d c%0d lane%0d: got %b want %b", g, c, i, bus.reqFinish[i], act[i] && c > doneAt[i]); end
               checks++; if (bus.rdataValid[i] !== (act[i] && ld[i] && c >= doneAt[i])) begin failures++; $display("FAIL rnd_valid g%0d c%0d lane%0d: got %b want %b", g, c, i, bus.rdataValid[i], act[i] && ld[i] && c >= doneAt[i]); end
               if (act[i] && ld[i] && c >= doneAt[i]) begin
                  want = refExt(word[i], lo[i], sz[i], uns[i]);
                  checks++; if (bus.rdata[i] !== want) begin failures++; $display("FAIL rnd_rdata g%0d c%0d lane%0d: got %h want %h", g, c, i, bus.rdata[i], want); end
               end
            end
            nextCycle();
            if (adv) break;
         end
         idleInputs();
         if (($urandom % 2) == 1) nextCycle();
      end
   endtask

   initial begin
      test_reset();
      test_load_same_cycle();
      test_byte_wait(1'b0);
      test_byte_wait(1'b1);
      test_joint_stall();
      test_flush_drain();
      test_reset_mid();
      test_both_lhu();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
